// File: rtl/delay_line_pkg.sv
// Shared constants and helpers for the delay_line slice.
package delay_line_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Width of the fill counter: enough bits to represent 0..depth.
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dl_stage.sv
// One delay-line stage: a data register plus its valid flag.
module dl_stage
  import delay_line_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Data shifts whenever enabled (even on flush); the valid flag is cleared by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      if (en) q <= d;
      if (flush)   q_valid <= 1'b0;
      else if (en) q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/delay_line.sv
// Enabled, flushable delay line of DEPTH stages with a running fill count.
module delay_line
  import delay_line_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [fill_width(DEPTH)-1:0] fill
);

  localparam int unsigned FW = fill_width(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [DEPTH-1:0] stage_v;
  logic             in_v;
  logic             out_v;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      dl_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .q       (stage_q[i]),
        .q_valid (stage_v[i])
      );
    end else begin : g_body
      dl_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (stage_q[i-1]),
        .d_valid (stage_v[i-1]),
        .q       (stage_q[i]),
        .q_valid (stage_v[i])
      );
    end
  end

  assign q       = stage_q[DEPTH-1];
  assign q_valid = stage_v[DEPTH-1];

  // A valid sample enters or leaves only on an enabled edge.
  always_comb begin
    in_v  = en & d_valid;
    out_v = en & stage_v[DEPTH-1];
  end

  // Up/down occupancy counter tracking the number of set valid flags.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      fill <= '0;
    end else if (in_v && !out_v && (fill != FW'(DEPTH))) begin
      fill <= fill + FW'(1);
    end else if (!in_v && out_v && (fill != '0)) begin
      fill <= fill - FW'(1);
    end
  end

endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line (DEPTH=4 and DEPTH=1 instances).
module tb_delay_line;

  logic       clk = 1'b0;
  logic       rst, en, flush, d_valid;
  logic [7:0] d;
  logic [7:0] q;
  logic       q_valid;
  logic [2:0] fill;

  logic       rst1, en1, flush1, d_valid1;
  logic [7:0] d1;
  logic [7:0] q1;
  logic       q_valid1;
  logic [0:0] fill1;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  delay_line #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q), .q_valid(q_valid), .fill(fill)
  );

  delay_line #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .flush(flush1), .d(d1), .d_valid(d_valid1),
    .q(q1), .q_valid(q_valid1), .fill(fill1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Reset with en, flush and d_valid all active: reset must win.
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; flush = 1'b1; d = 8'hFF; d_valid = 1'b1;
    step();
    step();
    rst = 1'b0; en = 1'b0; flush = 1'b0; d_valid = 1'b0;
    vectors++;
    if (q !== 8'h00 || q_valid !== 1'b0 || fill !== 3'd0) begin
      miscompares++;
      $display("FAIL reset q=%h qv=%b fill=%0d want q=00 qv=0 fill=0", q, q_valid, fill);
    end
  endtask

  task automatic test_stream();
    logic [7:0] din   [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] exp_q [8] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic       exp_v [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] exp_f [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    do_reset();
    en = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = din[i];
      step();
      vectors++;
      if (q !== exp_q[i] || q_valid !== exp_v[i] || fill !== exp_f[i]) begin
        miscompares++;
        $display("FAIL stream edge %0d q=%h qv=%b fill=%0d want q=%h qv=%b fill=%0d",
                 i + 1, q, q_valid, fill, exp_q[i], exp_v[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    en = 1'b1; d_valid = 1'b1;
    d = 8'h11; step();
    d = 8'h22; step();
    en = 1'b0; d = 8'hEE; d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (q !== 8'h00 || q_valid !== 1'b0 || fill !== 3'd2) begin
        miscompares++;
        $display("FAIL hold cycle %0d q=%h qv=%b fill=%0d want q=00 qv=0 fill=2",
                 i, q, q_valid, fill);
      end
    end
    en = 1'b1; d = 8'h00; d_valid = 1'b0;
    step();
    vectors++;
    if (q !== 8'h00 || q_valid !== 1'b0 || fill !== 3'd2) begin
      miscompares++;
      $display("FAIL hold_resume3 q=%h qv=%b fill=%0d want q=00 qv=0 fill=2", q, q_valid, fill);
    end
    step();
    vectors++;
    if (q !== 8'h11 || q_valid !== 1'b1 || fill !== 3'd2) begin
      miscompares++;
      $display("FAIL hold_resume4 q=%h qv=%b fill=%0d want q=11 qv=1 fill=2", q, q_valid, fill);
    end
    step();
    vectors++;
    if (q !== 8'h22 || q_valid !== 1'b1 || fill !== 3'd1) begin
      miscompares++;
      $display("FAIL hold_resume5 q=%h qv=%b fill=%0d want q=22 qv=1 fill=1", q, q_valid, fill);
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp_q [3] = '{8'h02, 8'h03, 8'hAA};
    do_reset();
    en = 1'b1; d_valid = 1'b1;
    d = 8'h01; step();
    d = 8'h02; step();
    d = 8'h03; step();
    vectors++;
    if (fill !== 3'd3) begin
      miscompares++;
      $display("FAIL flush_pre fill=%0d want 3", fill);
    end
    flush = 1'b1; d = 8'hAA; d_valid = 1'b1;
    step();
    vectors++;
    if (q !== 8'h01 || q_valid !== 1'b0 || fill !== 3'd0) begin
      miscompares++;
      $display("FAIL flush_edge q=%h qv=%b fill=%0d want q=01 qv=0 fill=0", q, q_valid, fill);
    end
    flush = 1'b0; d = 8'h00; d_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (q !== exp_q[i] || q_valid !== 1'b0 || fill !== 3'd0) begin
        miscompares++;
        $display("FAIL flush_drain %0d q=%h qv=%b fill=%0d want q=%h qv=0 fill=0",
                 i, q, q_valid, fill, exp_q[i]);
      end
    end
    // Flush with en=0: valid cleared, data not shifted.
    d = 8'h5A; d_valid = 1'b1; step();
    flush = 1'b1; en = 1'b0; d = 8'hC3; step();
    vectors++;
    if (fill !== 3'd0 || q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_noen fill=%0d qv=%b want fill=0 qv=0", fill, q_valid);
    end
    flush = 1'b0; en = 1'b1; d = 8'h00; d_valid = 1'b0;
    step(); step(); step();
    vectors++;
    if (q !== 8'h5A || q_valid !== 1'b0 || fill !== 3'd0) begin
      miscompares++;
      $display("FAIL flush_noen_data q=%h qv=%b fill=%0d want q=5a qv=0 fill=0", q, q_valid, fill);
    end
  endtask

  task automatic test_interleave();
    logic [7:0] exp_q [8] = '{8'h00, 8'h00, 8'h00, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    logic       exp_v [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] exp_f [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 8'hB1 + 8'(i);
      d_valid = (i % 2 == 0);
      step();
      vectors++;
      if (q !== exp_q[i] || q_valid !== exp_v[i] || fill !== exp_f[i]) begin
        miscompares++;
        $display("FAIL interleave edge %0d q=%h qv=%b fill=%0d want q=%h qv=%b fill=%0d",
                 i + 1, q, q_valid, fill, exp_q[i], exp_v[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    en = 1'b1; d_valid = 1'b1;
    d = 8'h61; step();
    d = 8'h62; step();
    d = 8'h63; step();
    rst = 1'b1; flush = 1'b0; d = 8'h64; step();
    rst = 1'b0;
    vectors++;
    if (q !== 8'h00 || q_valid !== 1'b0 || fill !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst q=%h qv=%b fill=%0d want q=00 qv=0 fill=0", q, q_valid, fill);
    end
    d = 8'h77; d_valid = 1'b1; step();
    d = 8'h00; d_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (q_valid !== 1'b0 || fill !== 3'd1) begin
        miscompares++;
        $display("FAIL midrst_lat %0d qv=%b fill=%0d want qv=0 fill=1", i + 2, q_valid, fill);
      end
    end
    step();
    vectors++;
    if (q !== 8'h77 || q_valid !== 1'b1 || fill !== 3'd1) begin
      miscompares++;
      $display("FAIL midrst_out q=%h qv=%b fill=%0d want q=77 qv=1 fill=1", q, q_valid, fill);
    end
  endtask

  task automatic test_depth1();
    logic [7:0] din [4] = '{8'h5A, 8'hA5, 8'h5A, 8'hA5};
    rst1 = 1'b1; en1 = 1'b0; flush1 = 1'b0; d1 = 8'h99; d_valid1 = 1'b1;
    step();
    rst1 = 1'b0;
    vectors++;
    if (q1 !== 8'h00 || q_valid1 !== 1'b0 || fill1 !== 1'b0) begin
      miscompares++;
      $display("FAIL d1_reset q=%h qv=%b fill=%0d want q=00 qv=0 fill=0", q1, q_valid1, fill1);
    end
    en1 = 1'b1; d_valid1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d1 = din[i];
      step();
      vectors++;
      if (q1 !== din[i] || q_valid1 !== 1'b1 || fill1 !== 1'b1) begin
        miscompares++;
        $display("FAIL d1_toggle %0d q=%h qv=%b fill=%0d want q=%h qv=1 fill=1",
                 i, q1, q_valid1, fill1, din[i]);
      end
    end
    en1 = 1'b0; d1 = 8'h33; d_valid1 = 1'b0; step();
    vectors++;
    if (q1 !== 8'hA5 || q_valid1 !== 1'b1 || fill1 !== 1'b1) begin
      miscompares++;
      $display("FAIL d1_hold q=%h qv=%b fill=%0d want q=a5 qv=1 fill=1", q1, q_valid1, fill1);
    end
    en1 = 1'b1; d1 = 8'h3C; step();
    vectors++;
    if (q1 !== 8'h3C || q_valid1 !== 1'b0 || fill1 !== 1'b0) begin
      miscompares++;
      $display("FAIL d1_invalid q=%h qv=%b fill=%0d want q=3c qv=0 fill=0", q1, q_valid1, fill1);
    end
    d1 = 8'h42; d_valid1 = 1'b1; step();
    rst1 = 1'b1; d1 = 8'hFF; step();
    rst1 = 1'b0;
    vectors++;
    if (q1 !== 8'h00 || q_valid1 !== 1'b0 || fill1 !== 1'b0) begin
      miscompares++;
      $display("FAIL d1_midrst q=%h qv=%b fill=%0d want q=00 qv=0 fill=0", q1, q_valid1, fill1);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; flush1 = 1'b0; d1 = '0; d_valid1 = 1'b0;
    #2;
    test_reset();
    test_stream();
    test_hold();
    test_flush();
    test_interleave();
    test_reset_midstream();
    test_depth1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
